// File: rtl/gradient_binarizer.sv
// rtl/gradient_binarizer.sv - thresholds Sobel gradients into packed edge bytes with an output FIFO (optional EDGE_COUNT_EN)
module gradient_binarizer #(
    parameter int GRAD_W         = 11,
    parameter int GRAD_PER_FRAME = 64516,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GRAD_W-1:0] gradient,
    input  logic              gradient_valid,
    input  logic [GRAD_W-1:0] threshold,
    output logic [7:0]        edge_byte,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              frame_done,
    output logic              overflow
`ifdef EDGE_COUNT_EN
    ,
    output logic [16:0]       edge_count
`endif
);

    localparam int CNT_W = $clog2(GRAD_PER_FRAME + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GRAD_W-1:0] thr_q, thr_d;
    logic [7:0]        pack_q, pack_d;
    logic [2:0]        idx_q, idx_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q;

    // Per-sample working values; a sample taken in IDLE starts from a clean packer.
    logic [GRAD_W-1:0] thr_use;
    logic              edge_bit;
    logic [CNT_W-1:0]  cnt_cur, cnt_new;
    logic [2:0]        idx_cur;
    logic [7:0]        pack_cur, pack_new;
    logic              last_sample;

    logic              push_req;
    logic [7:0]        push_byte;
    logic              drop_in;

`ifdef EDGE_COUNT_EN
    logic [16:0]       ec_cnt_q, ec_cnt_d;
    logic [16:0]       ec_out_q, ec_out_d;
    logic [16:0]       ec_cur, ec_new;
`endif

    // FIFO storage and pointers
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [7:0]        last_q;
    logic              pop, full, push_ok;

    assign thr_use     = (state_q == IDLE) ? threshold : thr_q;
    assign edge_bit    = (gradient >= thr_use);
    assign cnt_cur     = (state_q == IDLE) ? '0 : cnt_q;
    assign idx_cur     = (state_q == IDLE) ? 3'd0 : idx_q;
    assign pack_cur    = (state_q == IDLE) ? 8'd0 : pack_q;
    assign cnt_new     = cnt_cur + CNT_W'(1);
    assign pack_new    = pack_cur | (8'(edge_bit) << idx_cur);
    assign last_sample = (cnt_new == CNT_W'(GRAD_PER_FRAME));

`ifdef EDGE_COUNT_EN
    assign ec_cur = (state_q == IDLE) ? 17'd0 : ec_cnt_q;
    assign ec_new = ec_cur + 17'(edge_bit);
`endif

    // Next-state logic: packing, frame end handling and FIFO push requests.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        thr_d        = thr_q;
        pack_d       = pack_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        push_req     = 1'b0;
        push_byte    = pack_q;
        drop_in      = 1'b0;
`ifdef EDGE_COUNT_EN
        ec_cnt_d     = ec_cnt_q;
        ec_out_d     = ec_out_q;
`endif
        case (state_q)
            IDLE, ACCUM: begin
                if (gradient_valid) begin
                    thr_d = thr_use;
`ifdef EDGE_COUNT_EN
                    ec_cnt_d = ec_new;
`endif
                    if (idx_cur == 3'd7) begin
                        push_req  = 1'b1;
                        push_byte = pack_new;
                        pack_d    = 8'd0;
                        idx_d     = 3'd0;
                    end else begin
                        pack_d = pack_new;
                        idx_d  = idx_cur + 3'd1;
                    end
                    if (last_sample) begin
                        cnt_d = '0;
                        if (idx_cur == 3'd7) begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
`ifdef EDGE_COUNT_EN
                            ec_out_d = ec_new;
                            ec_cnt_d = 17'd0;
`endif
                        end else begin
                            state_d = FLUSH;
                        end
                    end else begin
                        cnt_d   = cnt_new;
                        state_d = ACCUM;
                    end
                end
            end
            FLUSH: begin
                push_req     = 1'b1;
                push_byte    = pack_q;
                pack_d       = 8'd0;
                idx_d        = 3'd0;
                state_d      = IDLE;
                frame_done_d = 1'b1;
                drop_in      = gradient_valid;
`ifdef EDGE_COUNT_EN
                ec_out_d = ec_cnt_q;
                ec_cnt_d = 17'd0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Framing state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            thr_q        <= '0;
            pack_q       <= 8'd0;
            idx_q        <= 3'd0;
            frame_done_q <= 1'b0;
`ifdef EDGE_COUNT_EN
            ec_cnt_q     <= 17'd0;
            ec_out_q     <= 17'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            thr_q        <= thr_d;
            pack_q       <= pack_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
`ifdef EDGE_COUNT_EN
            ec_cnt_q     <= ec_cnt_d;
            ec_out_q     <= ec_out_d;
`endif
        end
    end

    assign byte_valid = (occ_q != '0);
    assign full       = (occ_q == OCC_W'(FIFO_DEPTH));
    assign pop        = byte_valid && byte_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok    = push_req && (!full || pop);

    // FIFO data storage; no reset needed since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    // FIFO control, held output byte and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            last_q     <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            occ_q <= occ_q + OCC_W'(push_ok) - OCC_W'(pop);
            if ((push_req && !push_ok) || drop_in) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head of queue while data is present, otherwise the last byte consumed.
    assign edge_byte  = byte_valid ? mem_q[rd_ptr_q] : last_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
`ifdef EDGE_COUNT_EN
    assign edge_count = ec_out_q;
`endif

endmodule

// File: tb/tb_gradient_binarizer.sv
// tb/tb_gradient_binarizer.sv - directed self-checking bench for gradient_binarizer
module tb_gradient_binarizer;

    logic        clk;
    logic        rst;
    logic [10:0] gradient;
    logic        gradient_valid;
    logic [10:0] threshold;
    logic [7:0]  edge_byte;
    logic        byte_valid;
    logic        byte_ready;
    logic        frame_done;
    logic        overflow;
`ifdef EDGE_COUNT_EN
    logic [16:0] edge_count;
`endif

    int          n_checks;
    int          n_errors;
    int          fd_cnt;
    logic [7:0]  got[$];

    gradient_binarizer #(
        .GRAD_W(11),
        .GRAD_PER_FRAME(12),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gradient(gradient),
        .gradient_valid(gradient_valid),
        .threshold(threshold),
        .edge_byte(edge_byte),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .frame_done(frame_done),
        .overflow(overflow)
`ifdef EDGE_COUNT_EN
        ,
        .edge_count(edge_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record consumed bytes and frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) got.push_back(edge_byte);
        if (!rst && frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < got.size()) return 32'(got[i]);
        return 32'hDEAD;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] g);
        gradient       = g;
        gradient_valid = 1'b1;
        @(posedge clk);
        #1;
        gradient_valid = 1'b0;
    endtask

    // One 12-sample frame at threshold 1; bit i of bits becomes sample i.
    task automatic send_frame(input logic [11:0] bits, input int ready_at);
        threshold = 11'd1;
        for (int i = 0; i < 12; i++) begin
            if (i == ready_at) byte_ready = 1'b1;
            send(bits[i] ? 11'd5 : 11'd0);
        end
    endtask

    task automatic do_reset();
        gradient_valid = 1'b0;
        byte_ready     = 1'b1;
        rst            = 1'b1;
        idle(2);
        rst            = 1'b0;
        got.delete();
        fd_cnt         = 0;
    endtask

    initial begin
        logic [10:0] seq032 [12];
        n_checks  = 0;
        n_errors  = 0;
        fd_cnt    = 0;
        gradient  = '0;
        threshold = '0;
        #1;
        do_reset();

        @(negedge clk);
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_edge_byte", 32'(edge_byte), 0);
        idle(0);
        @(posedge clk);
        #1;

        // Reset mid-frame discards the partial frame
        threshold = 11'h100;
        repeat (5) send(11'h7FF);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        repeat (8) send(11'h7FF);
        idle(3);
        check("midrst_count", got.size(), 1);
        check("midrst_byte", q_at(0), 32'hFF);
        check("midrst_overflow", 32'(overflow), 0);
        do_reset();

        // Threshold boundary, padding and frame_done timing
        seq032 = '{11'd49, 11'd50, 11'd51, 11'd0, 11'd60, 11'd0,
                   11'd60, 11'd0, 11'd60, 11'd0, 11'd60, 11'd0};
        threshold = 11'd50;
        for (int i = 0; i < 12; i++) send(seq032[i]);
        @(negedge clk);
        check("fd_not_yet", 32'(frame_done), 0);
        @(negedge clk);
        check("fd_pulse", 32'(frame_done), 1);
`ifdef EDGE_COUNT_EN
        check("edge_count", 32'(edge_count), 6);
`endif
        idle(3);
        check("b032_count", got.size(), 2);
        check("b032_byte0", q_at(0), 32'h56);
        check("b032_byte1", q_at(1), 32'h05);
        check("b032_fd_once", fd_cnt, 1);
        do_reset();

        // Threshold latched on first sample only
        for (int i = 0; i < 12; i++) begin
            threshold = (i == 0) ? 11'd10 : 11'd200;
            send(11'd100);
        end
        idle(3);
        for (int i = 0; i < 12; i++) send(11'd100);
        idle(3);
        check("thr_count", got.size(), 4);
        check("thr_b0", q_at(0), 32'hFF);
        check("thr_b1", q_at(1), 32'h0F);
        check("thr_b2", q_at(2), 32'h00);
        check("thr_b3", q_at(3), 32'h00);
        check("thr_overflow", 32'(overflow), 0);

        // Sample arriving during FLUSH is dropped and flagged
        send_frame(12'hFFF, 99);
        send(11'd5);
        idle(3);
        check("flush_drop_ovf", 32'(overflow), 1);
        do_reset();

        // FIFO overflow with consumer stalled, then in-order drain
        byte_ready = 1'b0;
        send_frame(12'h211, 99);
        idle(2);
        send_frame(12'h433, 99);
        idle(2);
        send_frame(12'h655, 99);
        idle(2);
        check("ovf_byte_valid", 32'(byte_valid), 1);
        check("ovf_flag", 32'(overflow), 1);
        byte_ready = 1'b1;
        idle(10);
        check("ovf_count", got.size(), 4);
        check("ovf_b0", q_at(0), 32'h11);
        check("ovf_b1", q_at(1), 32'h02);
        check("ovf_b2", q_at(2), 32'h33);
        check("ovf_b3", q_at(3), 32'h04);
        check("empty_valid", 32'(byte_valid), 0);
        check("empty_hold", 32'(edge_byte), 32'h04);
        do_reset();

        // Full FIFO with simultaneous pop on the 8th-bit edge
        byte_ready = 1'b0;
        send_frame(12'h211, 99);
        idle(2);
        send_frame(12'h433, 99);
        idle(2);
        check("full_valid", 32'(byte_valid), 1);
        send_frame(12'h655, 7);
        idle(12);
        check("full_pop_ovf", 32'(overflow), 0);
        check("full_count", got.size(), 6);
        check("full_b0", q_at(0), 32'h11);
        check("full_b3", q_at(3), 32'h04);
        check("full_b4", q_at(4), 32'h55);
        check("full_b5", q_at(5), 32'h06);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
